// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: resolves memory wait
// states, taken branches/jumps and load-use hazards, with saturating counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_RegRs,
  input  logic [4:0]       ID_RegRt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegWrAddr,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [TO_W-1:0]  TIMEOUT = TO_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_next;
  logic            mem_busy;
  logic            load_use;
  logic            rs_hit;
  logic            rt_hit;

  assign mem_busy = (MEM_MemRead | MEM_MemWrite) & ~dmem_ready;
  assign rs_hit   = ID_UseRs & (ID_RegRs == EX_RegWrAddr);
  assign rt_hit   = ID_UseRt & (ID_RegRt == EX_RegWrAddr);
  assign load_use = EX_MemRead & (EX_RegWrAddr != 5'd0) & (rs_hit | rt_hit);
  // The cycle that first sees a busy memory already counts as wait cycle 1.
  assign wait_next = (state == RUN) ? TO_W'(1) : (wait_cnt + TO_W'(1));

  // Hazard priority: freeze (memory wait or error) > branch > load-use > jump.
  always_comb begin
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    flush_MEM_WB = 1'b0;
    if ((state == ERROR) || mem_busy) begin
      stall_PC     = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (EX_BranchTaken) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (load_use) begin
      stall_PC    = 1'b1;
      stall_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (ID_Jump) begin
      flush_IF_ID = 1'b1;
    end else begin
      flush_IF_ID = 1'b0;
    end
  end

  // Controller state, wait-cycle counter, halt flag and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_PC && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_IF_ID && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            wait_cnt <= wait_next;
            if (wait_next >= TIMEOUT) begin
              state  <= ERROR;
              halted <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        ERROR: begin
          state  <= ERROR;
          halted <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and small timeout/counter)
// checked by directed scenarios and a random run against a behavioural model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_RegRs, ID_RegRt, EX_RegWrAddr;
  logic        ID_UseRs, ID_UseRt, ID_Jump, EX_MemRead, EX_BranchTaken;
  logic        MEM_MemRead, MEM_MemWrite, dmem_ready;

  logic [7:0]  ctrl0, ctrl1;
  logic        s_pc0, s_ifid0, f_ifid0, f_idex0, s_idex0, s_exmem0, f_memwb0, halted0;
  logic        s_pc1, s_ifid1, f_ifid1, f_idex1, s_idex1, s_exmem1, f_memwb1, halted1;
  logic [15:0] stall_cnt0, flush_cnt0;
  logic [3:0]  stall_cnt1, flush_cnt1;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: 0 = defaults, 1 = MEM_TIMEOUT 4 / CNT_W 4.
  bit m_err[2];
  int m_wait[2], m_sc[2], m_fc[2];
  int m_to[2]  = '{255, 4};
  int m_max[2] = '{65535, 15};

  always #5 clk = ~clk;

  hazard_ctrl u0 (
    .clk(clk), .reset(reset), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrAddr(EX_RegWrAddr), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
    .stall_PC(s_pc0), .stall_IF_ID(s_ifid0), .flush_IF_ID(f_ifid0), .flush_ID_EX(f_idex0),
    .stall_ID_EX(s_idex0), .stall_EX_MEM(s_exmem0), .flush_MEM_WB(f_memwb0),
    .halted(halted0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrAddr(EX_RegWrAddr), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
    .stall_PC(s_pc1), .stall_IF_ID(s_ifid1), .flush_IF_ID(f_ifid1), .flush_ID_EX(f_idex1),
    .stall_ID_EX(s_idex1), .stall_EX_MEM(s_exmem1), .flush_MEM_WB(f_memwb1),
    .halted(halted1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  // Vector order: stall_PC stall_IF_ID flush_IF_ID flush_ID_EX stall_ID_EX stall_EX_MEM flush_MEM_WB halted
  assign ctrl0 = {s_pc0, s_ifid0, f_ifid0, f_idex0, s_idex0, s_exmem0, f_memwb0, halted0};
  assign ctrl1 = {s_pc1, s_ifid1, f_ifid1, f_idex1, s_idex1, s_exmem1, f_memwb1, halted1};

  function automatic logic [7:0] exp_ctrl(int i);
    bit busy, lu;
    busy = (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
    lu = EX_MemRead && (EX_RegWrAddr != 5'd0) &&
         ((ID_UseRs && ID_RegRs == EX_RegWrAddr) || (ID_UseRt && ID_RegRt == EX_RegWrAddr));
    if (m_err[i])       return 8'b1100_1111;
    if (busy)           return 8'b1100_1110;
    if (EX_BranchTaken) return 8'b0011_0000;
    if (lu)             return 8'b1101_0000;
    if (ID_Jump)        return 8'b0010_0000;
    return 8'b0000_0000;
  endfunction

  task automatic idle();
    ID_RegRs = 5'd0; ID_RegRt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrAddr = 5'd0; EX_BranchTaken = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  // Advance one clock: model consumes the current inputs at the edge; returns at negedge.
  task automatic tick();
    logic [7:0] e[2];
    bit busy;
    busy = (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
    for (int i = 0; i < 2; i++) e[i] = exp_ctrl(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_err[i] = 1'b0; m_wait[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (e[i][7] && m_sc[i] < m_max[i]) m_sc[i]++;
        if (e[i][5] && m_fc[i] < m_max[i]) m_fc[i]++;
        if (!m_err[i]) begin
          if (busy) begin
            m_wait[i]++;
            if (m_wait[i] >= m_to[i]) m_err[i] = 1'b1;
          end else begin
            m_wait[i] = 0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ctrl0 !== 8'h00 || ctrl1 !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl: got %b/%b expected 00000000", ctrl0, ctrl1);
    end
    checks++;
    if (stall_cnt0 !== 16'd0 || flush_cnt0 !== 16'd0 || stall_cnt1 !== 4'd0 || flush_cnt1 !== 4'd0) begin
      failures++; $display("FAIL reset_cnt: got %0d %0d %0d %0d expected all 0",
                           stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    EX_MemRead = 1'b1; EX_RegWrAddr = 5'd5; ID_RegRs = 5'd5; ID_UseRs = 1'b1;
    #1;
    checks++;
    if (ctrl0 !== 8'b1101_0000) begin
      failures++; $display("FAIL load_use_stall: got %b expected 11010000", ctrl0);
    end
    tick();
    idle();
    ID_RegRs = 5'd5; ID_UseRs = 1'b1;
    #1;
    checks++;
    if (ctrl0 !== 8'h00) begin
      failures++; $display("FAIL load_use_bubble: got %b expected 00000000", ctrl0);
    end
    checks++;
    if (stall_cnt0 !== 16'd1) begin
      failures++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt0);
    end
    tick();
  endtask

  task automatic test_no_stall();
    do_reset();
    EX_MemRead = 1'b1; EX_RegWrAddr = 5'd0; ID_RegRs = 5'd0; ID_UseRs = 1'b1;
    #1;
    checks++;
    if (ctrl0 !== 8'h00) begin
      failures++; $display("FAIL load_r0: got %b expected 00000000", ctrl0);
    end
    tick();
    EX_RegWrAddr = 5'd5; ID_RegRs = 5'd5; ID_UseRs = 1'b0;
    #1;
    checks++;
    if (ctrl0 !== 8'h00) begin
      failures++; $display("FAIL load_unused_rs: got %b expected 00000000", ctrl0);
    end
    tick();
    ID_RegRt = 5'd5; ID_UseRt = 1'b1;
    #1;
    checks++;
    if (ctrl0 !== 8'b1101_0000) begin
      failures++; $display("FAIL load_use_rt: got %b expected 11010000", ctrl0);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    EX_MemRead = 1'b1; EX_RegWrAddr = 5'd7; ID_RegRs = 5'd7; ID_UseRs = 1'b1;
    EX_BranchTaken = 1'b1;
    #1;
    checks++;
    if (ctrl0 !== 8'b0011_0000) begin
      failures++; $display("FAIL branch_over_lu: got %b expected 00110000", ctrl0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (flush_cnt0 !== 16'd1 || stall_cnt0 !== 16'd0) begin
      failures++; $display("FAIL branch_cnt: got flush %0d stall %0d expected 1 0", flush_cnt0, stall_cnt0);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    MEM_MemRead = 1'b1; dmem_ready = 1'b0; ID_Jump = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ctrl0 !== 8'b1100_1110) begin
        failures++; $display("FAIL mem_freeze cycle %0d: got %b expected 11001110", c, ctrl0);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl0 !== 8'b0010_0000) begin
      failures++; $display("FAIL mem_release_jump: got %b expected 00100000", ctrl0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (stall_cnt0 !== 16'd3 || flush_cnt0 !== 16'd1 || ctrl0 !== 8'h00) begin
      failures++; $display("FAIL mem_cnt: got stall %0d flush %0d ctrl %b expected 3 1 00000000",
                           stall_cnt0, flush_cnt0, ctrl0);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      checks++;
      if (halted1 !== (c >= 5)) begin
        failures++; $display("FAIL timeout_halt cycle %0d: got %b expected %b", c, halted1, (c >= 5));
      end
      tick();
    end
    dmem_ready = 1'b1; ID_Jump = 1'b1;
    #1;
    checks++;
    if (ctrl1 !== 8'b1100_1111) begin
      failures++; $display("FAIL error_sticky: got %b expected 11001111", ctrl1);
    end
    tick();
    do_reset();
    #1;
    checks++;
    if (ctrl1 !== 8'h00 || stall_cnt1 !== 4'd0 || flush_cnt1 !== 4'd0) begin
      failures++; $display("FAIL error_reset: got ctrl %b stall %0d flush %0d expected 00000000 0 0",
                           ctrl1, stall_cnt1, flush_cnt1);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      EX_MemRead = 1'b1; EX_RegWrAddr = 5'd3; ID_RegRt = 5'd3; ID_UseRt = 1'b1;
      tick();
      idle();
      tick();
    end
    #1;
    checks++;
    if (stall_cnt1 !== 4'd15) begin
      failures++; $display("FAIL stall_cnt_sat: got %0d expected 15", stall_cnt1);
    end
    checks++;
    if (stall_cnt0 !== 16'd20) begin
      failures++; $display("FAIL stall_cnt_wide: got %0d expected 20", stall_cnt0);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 79) == 0);
      ID_RegRs       = 5'($urandom_range(0, 3));
      ID_RegRt       = 5'($urandom_range(0, 3));
      ID_UseRs       = 1'($urandom_range(0, 1));
      ID_UseRt       = 1'($urandom_range(0, 1));
      ID_Jump        = ($urandom_range(0, 5) == 0);
      EX_MemRead     = 1'($urandom_range(0, 1));
      EX_RegWrAddr   = 5'($urandom_range(0, 3));
      EX_BranchTaken = ($urandom_range(0, 5) == 0);
      MEM_MemRead    = ($urandom_range(0, 3) == 0);
      MEM_MemWrite   = ($urandom_range(0, 5) == 0);
      dmem_ready     = ($urandom_range(0, 2) != 0);
      #1;
      if (!reset) begin
        checks++;
        if (ctrl0 !== exp_ctrl(0) || ctrl1 !== exp_ctrl(1)) begin
          failures++; $display("FAIL rand_ctrl n=%0d: got %b/%b expected %b/%b",
                               n, ctrl0, ctrl1, exp_ctrl(0), exp_ctrl(1));
        end
        checks++;
        if (stall_cnt0 !== 16'(m_sc[0]) || flush_cnt0 !== 16'(m_fc[0]) ||
            stall_cnt1 !== 4'(m_sc[1]) || flush_cnt1 !== 4'(m_fc[1])) begin
          failures++; $display("FAIL rand_cnt n=%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                               n, stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1,
                               m_sc[0], m_fc[0], m_sc[1], m_fc[1]);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush scheduler for the five-stage pipeline. It drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard classes: data-memory wait states, taken branches/jumps, and load-use dependencies. It also keeps saturating stall and flush counters, and raises a sticky error if data memory fails to respond.

Parameters:
MEM_TIMEOUT, 255, max consecutive wait cycles before entering ERROR (1..2^TO_W-1)
TO_W, 8, width of wait-cycle counter
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous active-high reset
ID_RegRs  in  5  rs field of instruction in ID
ID_RegRt  in  5  rt field of instruction in ID
ID_UseRs  in  1  ID instruction reads rs
ID_UseRt  in  1  ID instruction reads rt
ID_Jump  in  1  unconditional jump resolved in ID
EX_MemRead  in  1  instruction in EX is a load
EX_RegWrAddr  in  5  destination of instruction in EX
EX_BranchTaken  in  1  branch in EX resolved taken
MEM_MemRead  in  1  load in MEM
MEM_MemWrite  in  1  store in MEM
dmem_ready  in  1  data memory completes access this cycle
stall_PC  out  1  PC holds
stall_IF_ID  out  1  IF/ID holds
flush_IF_ID  out  1  IF/ID loads zero (nop)
flush_ID_EX  out  1  ID/EX loads zero (drives ID/EX register's clear input)
stall_ID_EX  out  1  ID/EX holds
stall_EX_MEM  out  1  EX/MEM holds
flush_MEM_WB  out  1  MEM/WB loads zero
halted  out  1  controller in ERROR
stall_cnt  out  CNT_W  cycles with stall_PC=1, saturating
flush_cnt  out  CNT_W  cycles with flush_IF_ID=1, saturating

Behaviour:
- Control outputs are combinational from registered state plus current inputs, so hazards are acted on in the cycle they are detected. Counters, wait counter and state are registered.
- States: RUN, MEM_WAIT, ERROR. Reset (sync, dominant over all inputs) -> RUN, wait counter=0, stall_cnt=0, flush_cnt=0, halted=0.
- Reset values of the control outputs are those of the RUN/no-hazard case: all 0.
- mem_busy = (MEM_MemRead | MEM_MemWrite) & ~dmem_ready.
- load_use = EX_MemRead & (EX_RegWrAddr!=0) & ((ID_UseRs & ID_RegRs==EX_RegWrAddr) | (ID_UseRt & ID_RegRt==EX_RegWrAddr)).
- Priority, highest first, in RUN or MEM_WAIT:
  1. mem_busy: stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM and flush_MEM_WB =1. All other outputs are 0. Branch, jump and load-use are ignored this cycle and re-evaluated once the freeze ends.
  2. EX_BranchTaken: flush_IF_ID=1, flush_ID_EX=1. This overrides load_use because the dependent instruction is squashed.
  3. load_use: stall_PC=1, stall_IF_ID=1, flush_ID_EX=1, giving exactly one bubble. The next cycle EX holds the bubble, so no re-trigger occurs.
  4. ID_Jump: flush_IF_ID=1 only.
  5. Otherwise all outputs are 0.
- A stall and a flush never both assert on the same register: flush_IF_ID and stall_IF_ID are mutually exclusive, as are flush_ID_EX and stall_ID_EX.
- RUN -> MEM_WAIT when mem_busy; the wait counter loads 1.
- MEM_WAIT: if mem_busy, the wait counter increments. When it reaches MEM_TIMEOUT while still busy, the next state is ERROR. If ~mem_busy, the next state is RUN, the wait counter clears, and that cycle is evaluated with RUN priority rules 2-5.
- ERROR: halted=1; stall_PC, stall_IF_ID, stall_ID_EX and stall_EX_MEM =1; flush_MEM_WB=1. All inputs are ignored and only reset exits this state.
- stall_cnt increments on each cycle with stall_PC=1, including ERROR. flush_cnt increments on each cycle with flush_IF_ID=1. Both hold at 2^CNT_W-1.
- Reset asserted mid-MEM_WAIT or in ERROR: the next cycle is RUN with zeroed counters.

Test Plan:
- EX load to $5 (EX_MemRead=1, EX_RegWrAddr=5), ID rs=5 with UseRs=1 -> exactly one cycle of stall_PC=stall_IF_ID=flush_ID_EX=1; the next cycle is all 0; stall_cnt=1.
- Load to $0 with ID rs=0, and separately a load to $5 with ID rs=5 but UseRs=0 -> no stall.
- EX_BranchTaken=1 together with load_use -> flush_IF_ID=flush_ID_EX=1, stall_PC=0; flush_cnt=1.
- MEM_MemRead=1 with dmem_ready low for 3 cycles, then high -> 3 cycles of full freeze with flush_MEM_WB=1; RUN on the 4th; stall_cnt=3. A concurrent ID_Jump is held back until cycle 4, where it gives flush_IF_ID=1.
- MEM_TIMEOUT=4 with dmem_ready stuck low -> halted=1 from the 5th cycle onward and stays high after dmem_ready rises; reset clears to RUN with counters=0.
- CNT_W=4 with 20 load-use events -> stall_cnt saturates at 15.
